// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/redirect arbiter.
package pipe_ctrl_pkg;

  localparam int unsigned PcWDefault     = 9;
  localparam int unsigned FlushCyclesMax = 7;

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StLuStall  = 3'd1,
    StMemWait  = 3'd2,
    StRedirect = 3'd3,
    StDrain    = 3'd4,
    StHalted   = 3'd5
  } pipe_state_e;

endpackage

// File: rtl/drain_counter.sv
// Down-counter for the wrong-path drain window: load, decrement, freeze and a
// flag for the last remaining cycle. Never wraps below zero.
module drain_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             freeze_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pipeline_control_arbiter.sv
// Central stall/flush/redirect arbiter: resolves EX, ID and data-memory requests
// by fixed priority into one consistent set of pipeline register controls.
module pipeline_control_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = PcWDefault,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_req,
  input  logic [PC_W-1:0] br_target,
  input  logic            lu_hazard,
  input  logic            mem_wait,
  input  logic            halt_req,
  input  logic            resume,
  output logic            stall_if,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            halted,
  output logic [2:0]      state_o
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

  pipe_state_e     state_q, state_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            pend_q, pend_d;
  logic            cnt_load, cnt_dec, cnt_last;

  drain_counter #(
    .Width (CntW)
  ) u_drain_counter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (CntW'(FLUSH_CYCLES - 1)),
    .dec_i      (cnt_dec),
    .freeze_i   (mem_wait),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    pend_d   = pend_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    pc_load  = 1'b0;
    halted   = 1'b0;

    case (state_q)
      StRun: begin
        if (br_req) tgt_d = br_target;
        if (halt_req) begin
          state_d = StHalted;
        end else if (mem_wait) begin
          state_d = StMemWait;
        end else if (br_req) begin
          state_d = StRedirect;
        end else if (lu_hazard) begin
          state_d = StLuStall;
        end
      end
      StLuStall: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        state_d  = mem_wait ? StMemWait : StRun;
      end
      StMemWait: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        // EX is held, so a branch seen here is remembered until memory releases.
        if (mem_wait) begin
          if (br_req && !pend_q) begin
            pend_d = 1'b1;
            tgt_d  = br_target;
          end
        end else begin
          pend_d  = 1'b0;
          state_d = pend_q ? StRedirect : StRun;
        end
      end
      StRedirect: begin
        pc_load  = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
        stall_ex = 1'b1;
        cnt_load = 1'b1;
        state_d  = (FLUSH_CYCLES > 1) ? StDrain : StRun;
      end
      StDrain: begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        stall_if = mem_wait;
        if (!mem_wait) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = StRun;
        end
      end
      StHalted: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        halted   = 1'b1;
        if (resume) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_target = tgt_q;
  assign state_o   = state_q;

  a_pc_load_pulse : assert property (@(posedge clk) disable iff (!reset) pc_load |=> !pc_load);
  a_state_legal   : assert property (@(posedge clk) disable iff (!reset) state_q <= StHalted);

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// Directed bench for pipeline_control_arbiter: a remaining-cycles model checked
// every cycle, plus literal expectations for each scenario.
module tb_pipeline_control_arbiter;

  localparam int unsigned PcW   = 9;
  localparam int unsigned Flush = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           br_req, lu_hazard, mem_wait, halt_req, resume;
  logic [PcW-1:0] br_target;
  logic           stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_load, halted;
  logic [PcW-1:0] pc_target;
  logic [2:0]     state_o;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_control_arbiter #(
    .PC_W         (PcW),
    .FLUSH_CYCLES (Flush)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .br_req    (br_req),
    .br_target (br_target),
    .lu_hazard (lu_hazard),
    .mem_wait  (mem_wait),
    .halt_req  (halt_req),
    .resume    (resume),
    .stall_if  (stall_if),
    .stall_id  (stall_id),
    .stall_ex  (stall_ex),
    .flush_id  (flush_id),
    .flush_ex  (flush_ex),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .halted    (halted),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [9:0] outs();
    return {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_load, halted, state_o};
  endfunction

  // Model: which activity is in progress and how many redirect cycles remain.
  bit             m_halted = 0, m_mw = 0, m_pend = 0, m_lu = 0, m_first = 0;
  int             m_left = 0;
  logic [PcW-1:0] m_tgt = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_halted <= 0; m_mw <= 0; m_pend <= 0; m_lu <= 0; m_first <= 0;
      m_left <= 0; m_tgt <= '0;
    end else if (m_halted) begin
      if (resume) m_halted <= 0;
    end else if (m_mw) begin
      if (mem_wait) begin
        if (br_req && !m_pend) begin
          m_pend <= 1;
          m_tgt  <= br_target;
        end
      end else begin
        m_mw <= 0;
        if (m_pend) begin
          m_pend <= 0; m_left <= Flush; m_first <= 1;
        end
      end
    end else if (m_left > 0) begin
      if (m_first) begin
        m_first <= 0; m_left <= m_left - 1;
      end else if (!mem_wait) begin
        m_left <= m_left - 1;
      end
    end else if (m_lu) begin
      m_lu <= 0;
      if (mem_wait) m_mw <= 1;
    end else begin
      if (halt_req) m_halted <= 1;
      else if (mem_wait) m_mw <= 1;
      else if (br_req) begin
        m_tgt <= br_target; m_left <= Flush; m_first <= 1;
      end else if (lu_hazard) m_lu <= 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0]     es;
    logic [9:0]     ev, av;
    logic [PcW-1:0] et, at;
    es = m_halted ? 3'd5 : m_mw ? 3'd2 : (m_left > 0) ? (m_first ? 3'd3 : 3'd4) :
         m_lu ? 3'd1 : 3'd0;
    case (es)
      3'd1:    ev = {7'b1100100, es};
      3'd2:    ev = {7'b1110000, es};
      3'd3:    ev = {7'b0011110, es};
      3'd4:    ev = {mem_wait, 6'b001100, es};
      3'd5:    ev = {7'b1110001, es};
      default: ev = {7'b0000000, es};
    endcase
    et = ev[4] ? m_tgt : '0;
    av = outs();
    at = ev[4] ? pc_target : '0;
    check("cycle_model", {13'b0, av, at}, {13'b0, ev, et});
  end

  task automatic set_in(input logic br, input logic [PcW-1:0] tg, input logic lu,
                        input logic mw, input logic ht, input logic rs);
    br_req = br; br_target = tg; lu_hazard = lu; mem_wait = mw; halt_req = ht; resume = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [PcW-1:0] tg, input logic lu,
                       input logic mw, input logic ht, input logic rs);
    set_in(br, tg, lu, mw, ht, rs);
    tick();
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    int n, np;
    reset = 1'b1;
    set_in(0, '0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("reset_outs", {22'b0, outs()}, 32'h0);
    check("reset_target", {23'b0, pc_target}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Branch redirect with a 3-cycle flush window.
    drive(1, 9'h05A, 0, 0, 0, 0);
    check("br_pc_load", {31'b0, pc_load}, 32'd1);
    check("br_target", {23'b0, pc_target}, 32'h05A);
    check("br_state", {29'b0, state_o}, 32'd3);
    n = 0; np = 0;
    for (int i = 0; i < 8 && state_o != 3'd0; i++) begin
      if (flush_id && flush_ex) n++;
      if (pc_load) np++;
      idle();
    end
    check("br_flush_cycles", n, 3);
    check("br_pc_load_pulses", np, 1);
    check("br_back_idle", {22'b0, outs()}, 32'h0);

    // Load-use hazard: one cycle of stall_if/stall_id/flush_ex only.
    drive(0, '0, 1, 0, 0, 0);
    check("lu_ctrl", {27'b0, stall_if, stall_id, stall_ex, flush_id, flush_ex}, 32'b11001);
    idle();
    check("lu_one_cycle", {22'b0, outs()}, 32'h0);

    // mem_wait for 4 cycles with a branch pending during the 2nd.
    drive(0, '0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall_if && stall_id && stall_ex) n++;
      drive(i == 0, (i == 0) ? 9'h100 : 9'h000, 0, i < 3, 0, 0);
    end
    check("mw_stall_cycles", n, 4);
    check("mw_pc_load", {31'b0, pc_load}, 32'd1);
    check("mw_target", {23'b0, pc_target}, 32'h100);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (state_o == 3'd4) n++;
    end
    check("mw_drain_cycles", n, 2);

    // Halt beats a simultaneous branch.
    drive(1, 9'h1FF, 0, 0, 1, 0);
    check("halt_state", {29'b0, state_o}, 32'd5);
    check("halt_flag_no_load", {30'b0, halted, pc_load}, 32'b10);
    idle();
    idle();
    check("halt_holds", {31'b0, halted}, 32'd1);
    drive(0, '0, 0, 0, 0, 1);
    check("resume_run", {28'b0, halted, state_o}, 32'd0);

    // mem_wait during the 2nd DRAIN cycle freezes the window for 2 cycles.
    drive(1, 9'h0AA, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 12 && state_o != 3'd0; i++) begin
      n++;
      set_in(0, '0, 0, (i == 2) || (i == 3), 0, 0);
      if (i == 2) begin
        #1;
        check("drain_mw_stall_if", {30'b0, stall_if, flush_id}, 32'b11);
      end
      tick();
    end
    check("drain_mw_length", n, 5);

    // Asynchronous reset in the middle of DRAIN.
    drive(1, 9'h133, 0, 0, 0, 0);
    idle();
    check("pre_reset_drain", {29'b0, state_o}, 32'd4);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", {22'b0, outs()}, 32'h0);
    check("async_reset_target", {23'b0, pc_target}, 32'h0);
    tick();
    reset = 1'b1;

    // mem_wait outranks branch and load-use; the dropped branch is not pended.
    drive(1, 9'h077, 1, 1, 0, 0);
    check("prio_memwait", {29'b0, state_o}, 32'd2);
    idle();
    check("prio_no_redirect", {28'b0, pc_load, state_o}, 32'd0);

    // Load-use stall followed by memory wait.
    drive(0, '0, 1, 0, 0, 0);
    drive(0, '0, 0, 1, 0, 0);
    check("lu_to_memwait", {29'b0, state_o}, 32'd2);
    idle();
    check("memwait_release", {29'b0, state_o}, 32'd0);

    idle();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/pipeline_control_arbiter.md
# pipeline_control_arbiter

Central stall/flush/redirect arbiter for the 5-stage pipelined CPU. It collects hazard and control requests from EX (branch taken with target, halt), ID (load-use hazard) and the data-memory port (wait) and resolves them by fixed priority. It drives one consistent set of stage stall, flush and PC-load controls to the IF/ID/EX pipeline registers and the PC mux. It replaces the per-source ad-hoc stall wiring with a single registered FSM.

## Interface
- PC_W, 9, PC and branch-target width
- FLUSH_CYCLES, 3, wrong-path flush cycles after a redirect, legal range 1..7
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- br_req  in  1  branch/jump taken, sampled level from EX
- br_target  in  PC_W  redirect target, valid with br_req
- lu_hazard  in  1  load-use hazard detected in ID
- mem_wait  in  1  data memory not ready
- halt_req  in  1  halt instruction in EX
- resume  in  1  leave HALTED
- stall_if, stall_id, stall_ex  out  1 each  hold the stage register
- flush_id, flush_ex  out  1 each  insert bubble into the stage register
- pc_load  out  1  load pc_target into PC
- pc_target  out  PC_W  registered redirect target
- halted  out  1  core halted
- state_o  out  3  current state encoding, for debug

## Operation
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, REDIRECT=3, DRAIN=4, HALTED=5. Outputs are Moore, decoded from registered state, plus stall_if in DRAIN while mem_wait.
- RUN: all outputs 0. Next-state priority is halt_req→HALTED, then mem_wait→MEM_WAIT, then br_req→REDIRECT, then lu_hazard→LU_STALL, else RUN. On br_req, tgt_q←br_target.
- LU_STALL: stall_if=stall_id=1, flush_ex=1, for one cycle. Next state is MEM_WAIT if mem_wait, else RUN.
- MEM_WAIT: stall_if=stall_id=stall_ex=1. Stays while mem_wait. br_req seen here sets pend_q and captures tgt_q, first request wins. When mem_wait falls, go to REDIRECT if pend_q (clear pend_q), else RUN. halt_req is ignored here because EX is held and will re-present it.
- REDIRECT: pc_load=1, pc_target=tgt_q, flush_id=flush_ex=1, stall_ex=1. cnt←FLUSH_CYCLES-1. Next state is DRAIN if FLUSH_CYCLES>1, else RUN.
- DRAIN: flush_id=flush_ex=1. cnt decrements each cycle and the state returns to RUN when cnt==1 is consumed. mem_wait freezes cnt and adds stall_if. br_req, halt_req and lu_hazard are ignored, since they come from wrong-path instructions.
- HALTED: stall_if=stall_id=stall_ex=1, halted=1. resume→RUN. All other inputs are ignored.
- pc_target always presents tgt_q. Its value is only meaningful while pc_load=1.

## Timing
- Reset (async assert, sync release): state=RUN, cnt=0, tgt_q=0, pend_q=0. Every output is 0 and state_o=0.
- Latency: an input sampled at edge k produces a response in the cycle after edge k. pc_load is a single-cycle pulse.
- A redirect occupies exactly FLUSH_CYCLES cycles (REDIRECT + DRAIN), plus any cycles frozen by mem_wait.
- Simultaneous inputs in RUN resolve strictly by the priority above. Lower-priority requests are dropped; ID and EX re-present them because the stages are held.
- Reset asserted mid-operation aborts immediately to RUN, and pend_q and tgt_q are cleared.
- cnt width is $clog2(FLUSH_CYCLES+1). cnt never wraps below 0.

## Structure
- pipe_ctrl_pkg holds the state enum typedef (3-bit), the PC_W default and the FLUSH_CYCLES maximum constant.
- One sub-module: drain_counter (load, decrement, freeze, last-cycle flag).

## Test plan
- Reset, then br_req=1, br_target=9'h05A for one cycle in RUN → next cycle pc_load=1 and pc_target=9'h05A; flush_id and flush_ex high for 3 consecutive cycles; return to RUN with all outputs 0.
- lu_hazard=1 for one cycle → exactly one cycle of stall_if=stall_id=flush_ex=1, stall_ex=0.
- mem_wait high 4 cycles, br_req (target 9'h100) pulsed during the 2nd → 4 cycles of full stall, then pc_load=1 with 9'h100, then 2 DRAIN cycles.
- halt_req and br_req together in RUN → HALTED, halted=1, no pc_load. resume=1 → RUN next cycle.
- mem_wait asserted in the 2nd DRAIN cycle for 2 cycles → cnt frozen, stall_if=1, and the redirect lasts 5 cycles in total.
- reset pulsed low during DRAIN → outputs 0 immediately (asynchronously), state_o=0.
